// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS receive checker: FSM states and
// default feedback masks for the supported LFSR lengths.
package prbs_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_chk_state_e;

   // x^8+x^6+x^5+x^4+1
   localparam logic [7:0] PRBS_TAPS_8 = 8'hB8;
   // x^7+x^6+1
   localparam logic [6:0] PRBS_TAPS_7 = 7'h60;

endpackage

// File: rtl/prbs_ref_lfsr.sv
// Local reference LFSR. Shifts either the received bit (while hunting)
// or its own feedback bit (while verifying/locked) into the LSB.
module prbs_ref_lfsr
   import prbs_pkg::*;
#(
   parameter int                 LENGTH = 8,
   parameter logic [LENGTH-1:0]  TAPS   = PRBS_TAPS_8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sel_fb,
   input  logic              d,
   output logic [LENGTH-1:0] state,
   output logic              pred
);

   logic [LENGTH-1:0] state_q;
   logic [LENGTH-1:0] state_d;
   logic              new_bit;

   // Prediction of the next stream bit from the current window.
   assign pred  = ^(state_q & TAPS);
   assign state = state_q;

   // Input mux and shift, same direction as the generator.
   always_comb begin
      new_bit = sel_fb ? pred : d;
      state_d = {state_q[LENGTH-2:0], new_bit};
   end

   // Shift register; advances only when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else if (en) begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises the reference LFSR to the incoming
// serial stream, declares lock after a run of correct predictions and
// keeps saturating error / bit statistics while locked.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int                LENGTH      = 8,
   parameter logic [LENGTH-1:0] TAPS        = PRBS_TAPS_8,
   parameter int                LOCK_COUNT  = 16,
   parameter int                LOSS_THRESH = 4,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_bit,
   input  logic              clear,
   output logic              locked,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  bit_count,
   output logic [LENGTH-1:0] ref_state
);

   localparam int FILL_W  = $clog2(LENGTH + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(LENGTH);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

   prbs_chk_state_e    state_q, state_d;
   logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic               err_pulse_q, err_pulse_d;

   logic               lfsr_en;
   logic               lfsr_sel_fb;
   logic               pred;
   logic               bit_match;
   logic [1:0]         stat_evt;     // [0] error, [1] bit checked
   logic [1:0][CNT_W-1:0] stat_cnt;

   prbs_ref_lfsr #(
      .LENGTH (LENGTH),
      .TAPS   (TAPS)
   ) u_ref (
      .clk    (clk),
      .rst    (rst),
      .en     (lfsr_en),
      .sel_fb (lfsr_sel_fb),
      .d      (in_bit),
      .state  (ref_state),
      .pred   (pred)
   );

   assign bit_match = (in_bit == pred);

   // Next-state logic for the lock FSM and its internal counters.
   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      lfsr_en     = 1'b0;
      lfsr_sel_fb = 1'b0;
      stat_evt    = 2'b00;
      err_pulse_d = 1'b0;

      if (in_valid) begin
         lfsr_en = 1'b1;
         unique case (state_q)
            HUNT: begin
               lfsr_sel_fb = 1'b0;
               if ((fill_cnt_q == FILL_FULL) && (ref_state != '0)) begin
                  // The window is full, so this bit is the first one that
                  // can be predicted; it counts towards the lock run.
                  state_d     = VERIFY;
                  match_cnt_d = bit_match ? MATCH_W'(1) : '0;
               end else if (fill_cnt_q != FILL_FULL) begin
                  fill_cnt_d = fill_cnt_q + FILL_W'(1);
               end
            end
            VERIFY: begin
               if (bit_match) begin
                  lfsr_sel_fb = 1'b1;
                  if (match_cnt_q >= MATCH_LAST) begin
                     state_d     = LOCKED;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + MATCH_W'(1);
                  end
               end else begin
                  // Restart the hunt with this bit as the first fill bit.
                  lfsr_sel_fb = 1'b0;
                  state_d     = HUNT;
                  fill_cnt_d  = FILL_W'(1);
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               lfsr_sel_fb = 1'b1;
               stat_evt[1] = 1'b1;
               if (!bit_match) begin
                  stat_evt[0] = 1'b1;
                  err_pulse_d = 1'b1;
                  if (miss_cnt_q == MISS_LAST) begin
                     state_d     = HUNT;
                     fill_cnt_d  = '0;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + MISS_W'(1);
                  end
               end else begin
                  miss_cnt_d = '0;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // FSM state, internal counters and the error pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   // Saturating statistics counters; clear is applied before the event.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stat
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic [CNT_W-1:0] base;

         // Clear first, then count the event unless already all-ones.
         always_comb begin
            base  = clear ? '0 : cnt_q;
            cnt_d = base;
            if (stat_evt[gi] && (base != '1)) begin
               cnt_d = base + CNT_W'(1);
            end
         end

         // Counter register.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign stat_cnt[gi] = cnt_q;
      end
   endgenerate

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = stat_cnt[0];
   assign bit_count = stat_cnt[1];

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus a
// randomized run against a behavioural model of the lock rules.
module tb_prbs_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       clear;

   logic        locked, err_pulse;
   logic [15:0] err_count, bit_count;
   logic [7:0]  ref_state;

   logic        locked_s, err_pulse_s;
   logic [3:0]  err_count_s, bit_count_s;
   logic [7:0]  ref_state_s;

   int checks = 0;
   int errors = 0;

   // behavioural model
   int         m_phase;   // 0 hunting, 1 verifying, 2 locked
   int         m_fill, m_match, m_miss;
   int         m_err, m_bits;
   logic [7:0] m_ref;
   logic       m_locked, m_pulse;

   logic [7:0] gen_q;

   always #5 clk = ~clk;

   prbs_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .bit_count (bit_count),
      .ref_state (ref_state)
   );

   prbs_checker #(.CNT_W(4)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clear     (clear),
      .locked    (locked_s),
      .err_pulse (err_pulse_s),
      .err_count (err_count_s),
      .bit_count (bit_count_s),
      .ref_state (ref_state_s)
   );

   // Reference generator: the new feedback bit is also the output bit.
   task automatic next_gen(output logic b);
      b     = ^(gen_q & 8'hB8);
      gen_q = {gen_q[6:0], b};
   endtask

   task automatic model_reset();
      m_phase = 0; m_fill = 0; m_match = 0; m_miss = 0;
      m_err = 0; m_bits = 0; m_ref = 8'h00;
      m_locked = 1'b0; m_pulse = 1'b0;
   endtask

   // Drive one cycle and advance the model by the specified rules.
   task automatic send(input logic v, input logic b, input logic c, input logic r);
      logic p;
      rst = r; in_valid = v; in_bit = b; clear = c;
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         m_pulse = 1'b0;
         if (c) begin
            m_err = 0; m_bits = 0;
         end
         if (v) begin
            p = ^(m_ref & 8'hB8);
            if (m_phase == 0) begin
               if (m_fill == 8 && m_ref != 8'h00) begin
                  m_phase = 1;
                  m_match = (b == p) ? 1 : 0;
               end else if (m_fill < 8) begin
                  m_fill++;
               end
               m_ref = {m_ref[6:0], b};
            end else if (m_phase == 1) begin
               if (b == p) begin
                  m_match++;
                  m_ref = {m_ref[6:0], p};
                  if (m_match >= 16) begin
                     m_phase = 2; m_miss = 0;
                  end
               end else begin
                  m_phase = 0; m_fill = 1; m_match = 0;
                  m_ref = {m_ref[6:0], b};
               end
            end else begin
               m_bits++;
               m_ref = {m_ref[6:0], p};
               if (b != p) begin
                  m_err++; m_pulse = 1'b1; m_miss++;
                  if (m_miss == 4) begin
                     m_phase = 0; m_fill = 0; m_miss = 0; m_match = 0;
                  end
               end else begin
                  m_miss = 0;
               end
            end
         end
         m_locked = (m_phase == 2);
      end
   endtask

   task automatic test_reset();
      send(1'b0, 1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b expected 0", err_pulse); end
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
      checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
      checks++; if (ref_state !== 8'h00) begin errors++; $display("FAIL reset_ref_state: got %h expected 00", ref_state); end
      $display("test_reset done");
   endtask

   task automatic test_clean_lock();
      logic b;
      send(1'b0, 1'b0, 1'b0, 1'b1);
      gen_q = 8'h01;
      for (int i = 1; i <= 24; i++) begin
         next_gen(b);
         send(1'b1, b, 1'b0, 1'b0);
         checks++; if (locked !== (i == 24)) begin errors++; $display("FAIL clean_lock_bit%0d: got %b expected %b", i, locked, (i == 24)); end
         checks++; if (ref_state !== m_ref) begin errors++; $display("FAIL clean_ref_bit%0d: got %h expected %h", i, ref_state, m_ref); end
      end
      for (int k = 1; k <= 20; k++) begin
         next_gen(b);
         send(1'b1, b, 1'b0, 1'b0);
         checks++; if (bit_count !== 16'(k)) begin errors++; $display("FAIL clean_bit_count: got %0d expected %0d", bit_count, k); end
         checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count: got %0d expected 0", err_count); end
         checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_stay_locked: got %b expected 1", locked); end
      end
      $display("test_clean_lock done");
   endtask

   task automatic test_single_error();
      logic b;
      next_gen(b);
      send(1'b1, ~b, 1'b0, 1'b0);
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b expected 1", err_pulse); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b expected 1", locked); end
      next_gen(b);
      send(1'b1, b, 1'b0, 1'b0);
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b expected 0", err_pulse); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_hold: got %0d expected 1", err_count); end
      // 3 misses, a match, 3 misses: lock must hold if the match cleared the miss run
      for (int i = 0; i < 7; i++) begin
         next_gen(b);
         send(1'b1, (i == 3) ? b : ~b, 1'b0, 1'b0);
         checks++; if (locked !== 1'b1) begin errors++; $display("FAIL miss_clear_locked%0d: got %b expected 1", i, locked); end
      end
      checks++; if (err_count !== 16'd7) begin errors++; $display("FAIL miss_clear_err_count: got %0d expected 7", err_count); end
      next_gen(b);
      send(1'b1, b, 1'b0, 1'b0);
      $display("test_single_error done");
   endtask

   task automatic test_loss();
      logic b;
      int   e0;
      e0 = int'(err_count);
      for (int j = 1; j <= 4; j++) begin
         next_gen(b);
         send(1'b1, ~b, 1'b0, 1'b0);
         checks++; if (locked !== (j < 4)) begin errors++; $display("FAIL loss_locked_miss%0d: got %b expected %b", j, locked, (j < 4)); end
      end
      checks++; if (err_count !== 16'(e0 + 4)) begin errors++; $display("FAIL loss_err_count: got %0d expected %0d", err_count, e0 + 4); end
      for (int i = 1; i <= 24; i++) begin
         next_gen(b);
         send(1'b1, b, 1'b0, 1'b0);
         checks++; if (locked !== (i == 24)) begin errors++; $display("FAIL relock_bit%0d: got %b expected %b", i, locked, (i == 24)); end
      end
      checks++; if (err_count !== 16'(e0 + 4)) begin errors++; $display("FAIL relock_err_retained: got %0d expected %0d", err_count, e0 + 4); end
      $display("test_loss done");
   endtask

   task automatic test_dead_line();
      logic b;
      send(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) begin
         send(1'b1, 1'b0, 1'b0, 1'b0);
         checks++; if (locked !== 1'b0 || ref_state !== 8'h00) begin errors++; $display("FAIL dead_line_bit%0d: got locked=%b ref=%h expected 0/00", i, locked, ref_state); end
      end
      gen_q = 8'h01;
      for (int i = 0; i < 150 && !m_locked; i++) begin
         next_gen(b);
         send(1'b1, b, 1'b0, 1'b0);
         checks++; if (locked !== m_locked || ref_state !== m_ref) begin errors++; $display("FAIL dead_recover_bit%0d: got %b/%h expected %b/%h", i, locked, ref_state, m_locked, m_ref); end
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL dead_relock: got %b expected 1", locked); end
      $display("test_dead_line done");
   endtask

   task automatic test_gapped();
      logic b;
      logic v;
      int   vb;
      send(1'b0, 1'b0, 1'b0, 1'b1);
      gen_q = 8'h01;
      vb = 0;
      for (int n = 0; n < 200 && vb < 24; n++) begin
         v = (n % 3 == 2);
         b = 1'($urandom_range(0, 1));
         if (v) begin
            next_gen(b);
            vb++;
         end
         send(v, b, 1'b0, 1'b0);
         checks++; if (locked !== (vb >= 24)) begin errors++; $display("FAIL gapped_locked_cyc%0d: got %b expected %b", n, locked, (vb >= 24)); end
         checks++; if (ref_state !== m_ref) begin errors++; $display("FAIL gapped_ref_cyc%0d: got %h expected %h", n, ref_state, m_ref); end
      end
      checks++; if (vb != 24 || locked !== 1'b1) begin errors++; $display("FAIL gapped_final: got locked=%b after %0d bits expected 1 after 24", locked, vb); end
      $display("test_gapped done");
   endtask

   task automatic test_clear_and_reset();
      logic b;
      next_gen(b);
      send(1'b1, ~b, 1'b1, 1'b0);
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clear_err_count: got %0d expected 1", err_count); end
      checks++; if (bit_count !== 16'd1) begin errors++; $display("FAIL clear_bit_count: got %0d expected 1", bit_count); end
      checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL clear_pulse_lock: got %b/%b expected 1/1", err_pulse, locked); end
      next_gen(b);
      send(1'b1, b, 1'b1, 1'b0);
      checks++; if (err_count !== 16'd0 || bit_count !== 16'd1) begin errors++; $display("FAIL clear_match: got %0d/%0d expected 0/1", err_count, bit_count); end
      next_gen(b);
      send(1'b1, b, 1'b0, 1'b1);
      checks++; if ({locked, err_pulse, err_count, bit_count, ref_state} !== '0) begin errors++; $display("FAIL midlock_reset: got %b %b %0d %0d %h expected all 0", locked, err_pulse, err_count, bit_count, ref_state); end
      for (int i = 1; i <= 24; i++) begin
         next_gen(b);
         send(1'b1, b, 1'b0, 1'b0);
         checks++; if (locked !== (i == 24)) begin errors++; $display("FAIL reset_relock_bit%0d: got %b expected %b", i, locked, (i == 24)); end
      end
      $display("test_clear_and_reset done");
   endtask

   task automatic test_random();
      logic b, v, c, e;
      logic [3:0] es, bs;
      send(1'b0, 1'b0, 1'b0, 1'b1);
      gen_q = 8'h5A;
      for (int n = 0; n < 1500; n++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 59) == 0);
         e = ($urandom_range(0, 39) == 0);
         b = 1'($urandom_range(0, 1));
         if (v) begin
            next_gen(b);
            b = b ^ e;
         end
         send(v, b, c, 1'b0);
         es = (m_err  > 15) ? 4'hF : 4'(m_err);
         bs = (m_bits > 15) ? 4'hF : 4'(m_bits);
         checks++;
         if (locked !== m_locked || err_pulse !== m_pulse || err_count !== 16'(m_err) ||
             bit_count !== 16'(m_bits) || ref_state !== m_ref) begin
            errors++;
            $display("FAIL random_cyc%0d: got %b %b %0d %0d %h expected %b %b %0d %0d %h",
                     n, locked, err_pulse, err_count, bit_count, ref_state,
                     m_locked, m_pulse, m_err, m_bits, m_ref);
         end
         checks++;
         if (err_count_s !== es || bit_count_s !== bs) begin
            errors++;
            $display("FAIL random_sat_cyc%0d: got %0d/%0d expected %0d/%0d", n, err_count_s, bit_count_s, es, bs);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
      model_reset();
      gen_q = 8'h01;
      test_reset();
      test_clean_lock();
      test_single_error();
      test_loss();
      test_dead_line();
      test_gapped();
      test_clear_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receive-side counterpart to the shift-register pattern generator. Accepts one bit per valid cycle and self-synchronises a local Fibonacci LFSR to the incoming stream. Once locked, predicts each following bit and counts mismatches. Sits at the far end of a serial test link and reports lock status plus error and bit statistics.

## Interface
- `LENGTH`, 8: LFSR length in bits (≥3).
- `TAPS`, 8'hB8: feedback mask. Predicted bit = XOR-reduce(`ref_state & TAPS`). Default is x^8+x^6+x^5+x^4+1.
- `LOCK_COUNT`, 16: consecutive correct predictions required to declare lock.
- `LOSS_THRESH`, 4: consecutive mispredictions while locked that drop lock.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_bit` in 1: received serial bit.
- `clear` in 1: synchronous clear of the statistics counters. Does not affect lock.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse per mismatch counted while locked.
- `err_count` out `CNT_W`: mismatches counted while locked. Saturating.
- `bit_count` out `CNT_W`: bits checked while locked. Saturating.
- `ref_state` out `LENGTH`: local LFSR contents, for debug.

## Operation
- Shift direction matches the generator: `ref_state <= {ref_state[LENGTH-2:0], new_bit}`.
- All state changes happen only on `in_valid` cycles. When `in_valid` is low, everything holds, except that `err_pulse` returns to 0.
- **HUNT** (reset state):
  - Each valid bit shifts `in_bit` into `ref_state`.
  - `fill_cnt` increments and saturates at `LENGTH`.
  - Transition to VERIFY on a valid cycle where `fill_cnt` is already `LENGTH` and `ref_state` ≠ 0.
  - If `ref_state` is all-zero, stay in HUNT and keep shifting. This prevents false lock on a dead (constant-zero) line.
- **VERIFY**:
  - Each valid bit is compared with the predicted bit.
  - `ref_state` shifts in the predicted bit (free-running).
  - On a match, `match_cnt` increments; reaching `LOCK_COUNT` moves to LOCKED.
  - On a mismatch, go to HUNT and clear `fill_cnt` and `match_cnt`. The received bit is shifted in as the first fill bit.
  - No statistics are updated in VERIFY.
- **LOCKED**:
  - Prediction and free-running shift as in VERIFY.
  - `bit_count` increments on every valid bit.
  - On a mismatch: `err_count` increments, `err_pulse` fires, and `miss_cnt` increments.
  - On a match, `miss_cnt` clears.
  - When `miss_cnt` reaches `LOSS_THRESH`, go to HUNT with `fill_cnt` cleared. `err_count` and `bit_count` keep their values.
- **Counters**: both saturate at all-ones and never wrap.
- **`clear` priority**:
  - `clear` zeroes both counters.
  - If `clear` and a counted event occur in the same cycle, the counter takes the value 1, i.e. the clear applies first and then the event counts.
- **`rst`**: all state is zeroed at any time, including mid-lock, and the FSM returns to HUNT.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `bit_count`=0, `ref_state`=0.
- `locked` rises on the clock edge that samples the `LOCK_COUNT`-th consecutive match. It is therefore visible the cycle after that bit.
- Minimum lock latency from reset with a continuous valid stream: `LENGTH`+1+`LOCK_COUNT`−1 = `LENGTH`+`LOCK_COUNT` valid bits. The "+1" is the transition cycle; the default is 24.
- `err_pulse` and the `err_count` update appear the cycle after the erroneous bit is sampled.
- `locked` falls the cycle after the `LOSS_THRESH`-th consecutive miss.
- Throughput: one bit per clock. There is no back-pressure.

## Structure
- **Package `prbs_pkg`**:
  - `typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} prbs_chk_state_e`.
  - Default tap constants per supported length: `PRBS_TAPS_8` = 8'hB8, `PRBS_TAPS_7` = 7'h60.
- **Sub-module `prbs_ref_lfsr`**:
  - A `LENGTH`-bit shift register with a 2:1 input mux selecting the external bit or the feedback bit.
  - Ports `clk`, `rst`, `en`, `sel_fb`, `d`; outputs `state` and `pred`.
- **`prbs_checker`**: owns the FSM, the three internal counters (`fill_cnt`, `match_cnt`, `miss_cnt`), and the statistics counters.

## Test plan
- **Clean lock:** reset, then feed a continuous x^8+x^6+x^5+x^4+1 stream seeded 8'h01 → `locked`=1 exactly one cycle after the 24th valid bit; `err_count`=0; `bit_count` increments by 1 per valid bit thereafter.
- **Single error:** after lock, invert one bit → exactly one `err_pulse`, `err_count`=1, `locked` stays 1; the next bit matches and `miss_cnt` clears.
- **Loss of lock:** after lock, invert 4 consecutive bits → `locked`=0 the cycle after the 4th, `err_count`=4 retained; a clean stream then relocks after 24 more valid bits.
- **Dead line:** 200 valid bits of constant 0 → `locked` never rises and `ref_state` stays 0; then switch to the clean stream → lock follows.
- **Gapped valid:** same stream as the clean-lock case but `in_valid` high every third cycle → lock after 24 valid bits; all state held on invalid cycles.
- **Clear and reset:** `clear` asserted in the same cycle as a locked mismatch → `err_count`=1. `rst` asserted while locked → all outputs 0 the next cycle and FSM in HUNT.
